// File: rtl/act_seq_pkg.sv
// Shared types and default widths for the activation sequencer.
package act_seq_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_LEN_WIDTH  = 9;
  localparam int unsigned DEF_ACT_LAT    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Two spare entries beyond the pipeline depth let reads stream back-to-back.
  function automatic int unsigned fifo_depth(input int unsigned act_lat);
    return act_lat + 2;
  endfunction

endpackage

// File: rtl/act_seq_fifo.sv
// Synchronous FIFO with flush; head is read from the registered storage array.
module act_seq_fifo #(
  parameter  int unsigned DEPTH = 5,
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/act_seq_ctrl.sv
// Streams a source buffer through a fixed-latency activation unit into a destination buffer.
// Optional abort support is enabled by defining ACT_SEQ_ABORT_EN.
module act_seq_ctrl
  import act_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int unsigned ACT_LAT    = DEF_ACT_LAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_src_base,
  input  logic [ADDR_WIDTH-1:0] cfg_dst_base,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] act_x,
  output logic                  act_x_valid,
  input  logic [DATA_WIDTH-1:0] act_y,
  output logic                  wr_en,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  localparam int unsigned DEPTH = fifo_depth(ACT_LAT);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned CW    = $clog2(2 * DEPTH + 2);

  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_base_q, src_base_d;
  logic [ADDR_WIDTH-1:0] dst_base_q, dst_base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
  logic [LEN_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
  logic [ACT_LAT:0]      vld_q, vld_d;

  logic                  abort_hit;
  logic                  push, pop, flush;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [CW-1:0]         in_flight;
  logic                  credit_ok;

`ifdef ACT_SEQ_ABORT_EN
  assign abort_hit = abort && (state_q == ST_RUN || state_q == ST_DRAIN);
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign abort_hit    = 1'b0;
`endif

  assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);
  assign act_x       = rd_data;
  assign act_x_valid = vld_q[0];
  assign push        = vld_q[ACT_LAT] && !abort_hit;
  assign rd_addr     = src_base_q + ADDR_WIDTH'(issue_cnt_q);
  assign wr_addr     = dst_base_q + ADDR_WIDTH'(wr_cnt_q);
  assign wr_data     = fifo_empty ? '0 : fifo_head;

  // Every valid-pipeline stage, including the one pushing this cycle, holds a reserved slot.
  always_comb begin
    in_flight = '0;
    for (int unsigned i = 0; i <= ACT_LAT; i++) begin
      in_flight = in_flight + CW'(vld_q[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    src_base_d  = src_base_q;
    dst_base_d  = dst_base_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    flush       = 1'b0;
    rd_en       = 1'b0;

    wr_en = !fifo_empty && !abort_hit;
    pop   = wr_en && wr_ready;
    if (pop) wr_cnt_d = wr_cnt_q + LEN_WIDTH'(1);

    // A pop this cycle frees a slot in time for the read issued now.
    credit_ok = (CW'(fifo_count) + in_flight) < (CW'(DEPTH) + CW'(pop));

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_base_d  = cfg_src_base;
          dst_base_d  = cfg_dst_base;
          len_d       = cfg_len;
          issue_cnt_d = '0;
          wr_cnt_d    = '0;
          state_d     = (cfg_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        rd_en = (issue_cnt_q < len_q) && credit_ok && !abort_hit;
        if (rd_en) issue_cnt_d = issue_cnt_q + LEN_WIDTH'(1);
        if (issue_cnt_d == len_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (wr_cnt_d == len_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    vld_d = {vld_q[ACT_LAT-1:0], rd_en};

    if (abort_hit) begin
      state_d = ST_IDLE;
      vld_d   = '0;
      flush   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      src_base_q  <= '0;
      dst_base_q  <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      wr_cnt_q    <= '0;
      vld_q       <= '0;
    end else begin
      state_q     <= state_d;
      src_base_q  <= src_base_d;
      dst_base_q  <= dst_base_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      vld_q       <= vld_d;
    end
  end

  act_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (act_y),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // The credit rule must keep a result from ever arriving at a full FIFO.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_act_seq_ctrl.sv
// Directed self-checking bench for act_seq_ctrl with a behavioural buffer and activation unit.
module tb_act_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cfg_src_base = '0;
  logic [7:0]  cfg_dst_base = '0;
  logic [8:0]  cfg_len = '0;
  logic        abort = 1'b0;
  logic        busy, done, rd_en, act_x_valid, wr_en;
  logic        wr_ready = 1'b1;
  logic [7:0]  rd_addr, wr_addr;
  logic [15:0] rd_data = '0;
  logic [15:0] act_x, act_y, wr_data;
  logic [15:0] act_pipe [3];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  act_seq_ctrl #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (8),
    .LEN_WIDTH  (9),
    .ACT_LAT    (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_src_base (cfg_src_base),
    .cfg_dst_base (cfg_dst_base),
    .cfg_len      (cfg_len),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .act_x        (act_x),
    .act_x_valid  (act_x_valid),
    .act_y        (act_y),
    .wr_en        (wr_en),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] src_val(input logic [7:0] a);
    return {a ^ 8'h5A, a};
  endfunction

  // Source buffer with one-cycle read latency; activation unit computes x+1 over three stages.
  always @(posedge clk) if (rd_en) rd_data <= src_val(rd_addr);
  always @(posedge clk) begin
    act_pipe[0] <= act_x + 16'd1;
    act_pipe[1] <= act_pipe[0];
    act_pipe[2] <= act_pipe[1];
  end
  assign act_y = act_pipe[2];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq(tag, 64'({busy, done, rd_en, act_x_valid, wr_en, rd_addr, wr_addr, wr_data}), 64'd0);
  endtask

  task automatic run_job(input string name, input logic [7:0] src, input logic [7:0] dst,
                         input logic [8:0] len, input int stall_lo, input int stall_hi,
                         input int abort_rel, input int start_rel, input bit pulse_in_done,
                         input int exp_done_rel);
    int t0, rel, rd_n, wr_n, done_n, wr_post, first_rd, first_wr, done_rel, max_out, exp_max;
    bit abort_on;
    logic [7:0] ea;
    rd_n = 0; wr_n = 0; done_n = 0; wr_post = 0; max_out = 0;
    first_rd = -1; first_wr = -1; done_rel = -1; rel = 0;
`ifdef ACT_SEQ_ABORT_EN
    abort_on = (abort_rel > 0);
`else
    abort_on = 1'b0;
`endif
    exp_max = (len < 9'd5) ? int'(len) : 5;
    @(negedge clk);
    start = 1'b1; cfg_src_base = src; cfg_dst_base = dst; cfg_len = len;
    wr_ready = 1'b1; abort = 1'b0;
    t0 = cyc;
    while (rel < 200) begin
      @(negedge clk);
      rel = cyc - t0;
      start = (rel == start_rel) || (pulse_in_done && rel == exp_done_rel);
      cfg_src_base = 8'h33; cfg_dst_base = 8'h44; cfg_len = 9'd7;
      wr_ready = !(rel >= stall_lo && rel <= stall_hi);
      abort = (rel == abort_rel);
      #1;
      if (rd_en) begin
        ea = src + 8'(rd_n);
        check_eq({name, " rd_addr"}, 64'(rd_addr), 64'(ea));
        if (first_rd < 0) first_rd = rel;
        rd_n++;
      end
      if (wr_en && wr_ready) begin
        ea = dst + 8'(wr_n);
        check_eq({name, " wr_addr"}, 64'(wr_addr), 64'(ea));
        ea = src + 8'(wr_n);
        check_eq({name, " wr_data"}, 64'(wr_data), 64'(src_val(ea) + 16'd1));
        if (first_wr < 0) first_wr = rel;
        if (abort_on && rel > abort_rel) wr_post++;
        wr_n++;
      end
      if (done) begin
        done_n++;
        if (done_rel < 0) done_rel = rel;
      end
      if (rd_n - wr_n > max_out) max_out = rd_n - wr_n;
      if (abort_on) begin
        if (rel == abort_rel) check_eq({name, " abort_rd_wr_en"}, 64'({rd_en, wr_en}), 64'd0);
        if (rel == abort_rel + 1) check_eq({name, " abort_busy"}, 64'(busy), 64'd0);
        if (rel == abort_rel + 15) break;
      end else begin
        check_eq({name, " busy"}, 64'(busy), 64'((len != 9'd0) && rel >= 1 && done_n == 0));
        if (done_rel >= 0 && rel == done_rel + 3) break;
      end
    end
    start = 1'b0; abort = 1'b0; wr_ready = 1'b1;
    check_eq({name, " no_timeout"}, 64'(rel < 200), 64'd1);
    if (abort_on) begin
      check_eq({name, " abort_done_cnt"}, 64'(done_n), 64'd0);
      check_eq({name, " abort_post_writes"}, 64'(wr_post), 64'd0);
    end else begin
      check_eq({name, " rd_count"}, 64'(rd_n), 64'(len));
      check_eq({name, " wr_count"}, 64'(wr_n), 64'(len));
      check_eq({name, " done_count"}, 64'(done_n), 64'd1);
      check_eq({name, " done_cycle"}, 64'(done_rel), 64'(exp_done_rel));
      check_eq({name, " max_outstanding"}, 64'(max_out), 64'(exp_max));
      if (len != 9'd0) begin
        check_eq({name, " first_rd"}, 64'(first_rd), 64'd1);
        check_eq({name, " first_wr"}, 64'(first_wr), 64'd6);
      end
    end
  endtask

  initial begin
    int hits;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;

    //      name      src    dst    len   stall      abort start done  exp_done
    run_job("basic",  8'h10, 8'h80, 9'd4,  1000, -1, -1,   -1,   1'b0, 10);
    run_job("zero",   8'h10, 8'h80, 9'd0,  1000, -1, -1,   -1,   1'b0, 1);
    run_job("stall",  8'h20, 8'h40, 9'd20, 8,    20, -1,   -1,   1'b0, 39);
    run_job("wrap",   8'hFE, 8'hFE, 9'd4,  1000, -1, -1,   -1,   1'b0, 10);
    run_job("ignore", 8'h10, 8'h80, 9'd4,  1000, -1, -1,   3,    1'b1, 10);
    run_job("abort",  8'h00, 8'h90, 9'd10, 1000, -1, 8,    -1,   1'b0, 16);
    run_job("post",   8'h50, 8'hA0, 9'd4,  1000, -1, -1,   -1,   1'b0, 10);

    // Reset in the middle of a job: nothing may leak out afterwards.
    @(negedge clk);
    start = 1'b1; cfg_src_base = 8'h60; cfg_dst_base = 8'hB0; cfg_len = 9'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midjob_reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      #1;
      if (rd_en || wr_en || done || busy || act_x_valid) hits++;
    end
    check_eq("midjob_reset_quiet", 64'(hits), 64'd0);
    run_job("after_rst", 8'h70, 8'hC0, 9'd4, 1000, -1, -1, -1, 1'b0, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/act_seq_ctrl.md
ACT_SEQ_CTRL -- requirements
Module: act_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, Q8.8 sample width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, buffer address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 9, transfer-length width.
REQ-004 SHALL have parameter ACT_LAT, default 3, fixed activation-pipeline latency in cycles.
REQ-005 SHALL have ports clk in 1 (clock), then rst_n in 1 (reset, asynchronous, active-low).
REQ-006 SHALL have ports start in 1, cfg_src_base in ADDR_WIDTH, cfg_dst_base in ADDR_WIDTH, cfg_len in LEN_WIDTH (job command/config).
REQ-007 SHALL have ports abort in 1, busy out 1, done out 1 (one-cycle pulse).
REQ-008 SHALL have ports rd_en out 1, rd_addr out ADDR_WIDTH, rd_data in DATA_WIDTH (source buffer, read latency 1).
REQ-009 SHALL have ports act_x out DATA_WIDTH, act_x_valid out 1, act_y in DATA_WIDTH (free-running, non-stallable activation unit).
REQ-010 SHALL have ports wr_en out 1, wr_ready in 1, wr_addr out ADDR_WIDTH, wr_data out DATA_WIDTH (destination buffer).

Function
REQ-011 SHALL implement FSM IDLE, RUN, DRAIN, DONE; busy high in RUN and DRAIN only.
REQ-012 SHALL accept start only in IDLE, latching cfg_*; start in any other state, and later cfg changes, SHALL be ignored.
REQ-013 SHALL go IDLE->DONE when accepted cfg_len==0: no rd_en/wr_en, done the next cycle.
REQ-014 SHALL otherwise go IDLE->RUN; RUN->DRAIN when cfg_len reads issued; DRAIN->DONE when cfg_len writes accepted; DONE->IDLE after one cycle with done=1.
REQ-015 SHALL assert rd_en in RUN when issued<len and free_fifo_entries - in_flight > 0 (credit rule).
REQ-016 SHALL drive rd_addr = src_base + issue_cnt modulo 2^ADDR_WIDTH (wrap allowed).
REQ-017 SHALL drive act_x = rd_data combinationally, act_x_valid = rd_en delayed 1 cycle.
REQ-018 SHALL push act_y into the output FIFO exactly ACT_LAT cycles after each act_x_valid, never dropping a result.
REQ-019 SHALL size the output FIFO at ACT_LAT+2 entries, registered output; a push is visible to wr side the next cycle.
REQ-020 SHALL assert wr_en when FIFO non-empty; a write is accepted when wr_en&&wr_ready; wr_data = FIFO head, held stable until accepted.
REQ-021 SHALL drive wr_addr = dst_base + wr_cnt modulo 2^ADDR_WIDTH.
REQ-022 SHALL sustain one sample per cycle with wr_ready constantly high; start accepted at cycle T gives first rd_en at T+1, first wr_en at T+6 (ACT_LAT=3), done at T+6+len.
REQ-023 SHALL, with wr_ready low, stop issuing once credits exhausted and resume without loss or reorder.

Reset
REQ-024 SHALL on rst_n low force IDLE, clear counters, FIFO and valid pipeline, and drive busy, done, rd_en, act_x_valid, wr_en low, rd_addr, wr_addr, wr_data zero.
REQ-025 SHALL on reset mid-job discard all in-flight data with no write or done afterwards.

Configuration
REQ-026 SHALL with ACT_SEQ_ABORT_EN defined: abort in RUN/DRAIN deasserts rd_en/wr_en the same cycle, clears FIFO and valid pipeline, returns to IDLE next cycle, no done pulse; abort in IDLE/DONE has no effect.
REQ-027 SHALL without ACT_SEQ_ABORT_EN keep the abort port but ignore it entirely.

Structure
REQ-028 SHALL place FSM state enum and default widths in shared package act_seq_pkg.
REQ-029 SHALL implement the output FIFO as sub-module act_seq_fifo (sync, parameterised depth/width, push/pop/flush, full/empty/count).

Verification
REQ-030 SHALL cover len=4, src=0x10, dst=0x80, wr_ready=1, act_y=rd_data+1 -> writes 0x80..0x83 at T+6..T+9, done at T+10.
REQ-031 SHALL cover len=0 -> done at T+1, no rd_en/wr_en, busy stays low.
REQ-032 SHALL cover len=20, wr_ready low cycles 8-20 -> rd_en stops at 5 outstanding, all 20 writes in order, no overflow.
REQ-033 SHALL cover src=0xFE, len=4 -> rd_addr 0xFE,0xFF,0x00,0x01.
REQ-034 SHALL cover abort (macro on) mid-RUN of len=10 -> no further writes, no done, busy low next cycle, new start accepted.
REQ-035 SHALL cover start pulsed during RUN and in DONE -> ignored, one done per accepted job.
